error_comp_arbiter: RTL
=======================

Name: error_comp_arbiter

Overview:
Shares one error-compensation adder (16-bit error_sum + 24-bit partial_sum -> 24-bit sum) between NUM_LANES MAC lanes. Each lane offers a compensation request through a valid/ready handshake. The block grants lanes round-robin, steers the granted lane's operands onto the shared adder and registers the result with its lane ID. The result is held in a single-entry output buffer with backpressure. The block sits between the MAC PE lanes and the accumulator writeback.

Parameters:
NUM_LANES, 4, number of requesting MAC lanes (2..16)
LANE_W, $clog2(NUM_LANES), width of lane index fields

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
comp_en  input  1  1 = apply error compensation; 0 = adder sees error_sum forced to 0 (pass-through)
in_valid  input  NUM_LANES  per-lane request valid
in_ready  output  NUM_LANES  per-lane accept; one-hot or zero
in_error_sum  input  16*NUM_LANES  lane i error term in bits [16i+15:16i]
in_psum  input  24*NUM_LANES  lane i partial sum in bits [24i+23:24i]
adder_error_sum  output  16  operand to shared adder
adder_psum  output  24  operand to shared adder
adder_sum  input  24  combinational result from shared adder
out_valid  output  1  result buffer holds valid data
out_ready  input  1  downstream accepts result
out_sum  output  24  compensated partial sum
out_lane  output  LANE_W  lane that produced out_sum
comp_count  output  16  saturating count of compensated accepts

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_sum=0, out_lane=0, rr_ptr=0, comp_count=0. in_ready is combinational and is 0 while rst_n=0. A result pending at reset is dropped.
- slot_free = !out_valid || out_ready. Same-cycle drain and refill is allowed, so full throughput is 1 result/cycle.
- Arbitration is combinational. Search lanes rr_ptr, rr_ptr+1, ... mod NUM_LANES. The first lane with in_valid=1 is granted.
- in_ready[g] = slot_free && rst_n for the granted lane g only. All other in_ready bits are 0.
- Accept = in_valid[g] && in_ready[g]. On accept at edge: out_sum <= adder_sum, out_lane <= g, out_valid <= 1, rr_ptr <= (g+1) mod NUM_LANES.
- If there is no request, or slot_free=0: rr_ptr holds and the buffer holds.
- If out_valid && out_ready with no accept: out_valid <= 0. out_sum and out_lane keep their last values.
- Adder steering while a grant exists:
  - adder_psum = in_psum of lane g.
  - adder_error_sum = comp_en ? in_error_sum of lane g : 0.
  - With no grant, both operands are 0.
  - Operands follow the grant even when slot_free=0, but nothing is captured in that case.
- Latency: request accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Arithmetic: the adder wraps modulo 2^24; error_sum is zero-extended. The block does not saturate.
- comp_count increments on each accept with comp_en=1 and a nonzero lane error_sum. It saturates at 0xFFFF.
- comp_en is sampled in the accept cycle only. Changing it while a result is buffered does not alter out_sum.
- A lane must hold in_valid and its data stable until in_ready. The block never grants a lane with in_valid=0.
- Fairness: with all lanes requesting continuously and out_ready=1, the grant order is 0,1,...,N-1,0,... Each requesting lane is served within NUM_LANES accepts.

Test Plan:
- Reset: drive in_valid=4'b1111 with rst_n=0 for 2 cycles -> in_ready=0, out_valid=0, comp_count=0. First accept after release goes to lane 0.
- Single lane, comp_en=1: lane 2 offers error 0x0012, psum 0x000100 (adder model = add) -> next cycle out_valid=1, out_sum=0x000112, out_lane=2, comp_count=1.
- Round-robin: all 4 lanes valid, out_ready=1 for 8 cycles -> out_lane sequence 0,1,2,3,0,1,2,3. One result per cycle.
- Backpressure: out_ready=0 with result buffered and lanes 1,3 valid -> in_ready=0, out_sum stable. Raise out_ready -> lane 1 accepted the same cycle, then lane 3.
- Wrap and bypass: psum 0xFFFFF0, error 0x0020, comp_en=1 -> out_sum=0x000010. Repeat with comp_en=0 -> out_sum=0xFFFFF0, comp_count unchanged.
- Saturation and mid-op reset: preload comp_count to 0xFFFF via 65535 compensated accepts, then one more -> count stays 0xFFFF. Assert rst_n=0 with out_valid=1 -> out_valid=0 and count=0 next cycle.

Source files
------------

// File: rtl/error_comp_arbiter_if.sv
// rtl/error_comp_arbiter_if.sv - lane request and result handshake bundle for error_comp_arbiter
interface error_comp_arbiter_if #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = $clog2(NUM_LANES)
);
   logic [NUM_LANES-1:0]    in_valid;
   logic [NUM_LANES-1:0]    in_ready;
   logic [16*NUM_LANES-1:0] in_error_sum;
   logic [24*NUM_LANES-1:0] in_psum;
   logic                    out_valid;
   logic                    out_ready;
   logic [23:0]             out_sum;
   logic [LANE_W-1:0]       out_lane;

   // Upstream lanes and downstream writeback side
   modport master (
      output in_valid, in_error_sum, in_psum, out_ready,
      input  in_ready, out_valid, out_sum, out_lane
   );

   // Arbiter side
   modport slave (
      input  in_valid, in_error_sum, in_psum, out_ready,
      output in_ready, out_valid, out_sum, out_lane
   );
endinterface

// File: rtl/error_comp_arbiter.sv
// rtl/error_comp_arbiter.sv - round-robin sharing of one error-compensation adder across MAC lanes
module error_comp_arbiter #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = $clog2(NUM_LANES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      comp_en,
   error_comp_arbiter_if.slave       bus,
   output logic [15:0]               adder_error_sum,
   output logic [23:0]               adder_psum,
   input  logic [23:0]               adder_sum,
   output logic [15:0]               comp_count
);

   logic [LANE_W-1:0]    rr_ptr;
   logic                 out_valid_q;
   logic [23:0]          out_sum_q;
   logic [LANE_W-1:0]    out_lane_q;

   logic                 grant_valid;
   logic [LANE_W-1:0]    grant_idx;
   logic                 slot_free;
   logic                 accept;
   logic [15:0]          lane_err;
   logic [23:0]          lane_psum;
   logic [NUM_LANES-1:0] in_ready_c;
   logic [LANE_W-1:0]    next_ptr;

   // Rotating-priority search: first requesting lane at or after rr_ptr wins
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!grant_valid && bus.in_valid[(32'(rr_ptr) + 32'(k)) % NUM_LANES]) begin
            grant_valid = 1'b1;
            grant_idx   = LANE_W'((32'(rr_ptr) + 32'(k)) % NUM_LANES);
         end
      end
   end

   assign slot_free = !out_valid_q || bus.out_ready;
   assign accept    = grant_valid && slot_free && rst_n;
   assign lane_err  = bus.in_error_sum[32'(grant_idx)*16 +: 16];
   assign lane_psum = bus.in_psum[32'(grant_idx)*24 +: 24];
   assign next_ptr  = (32'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + 1'b1;

   // Grant-steered adder operands and one-hot ready; operands track the grant even when stalled
   always_comb begin
      in_ready_c      = '0;
      adder_psum      = 24'd0;
      adder_error_sum = 16'd0;
      if (grant_valid) begin
         adder_psum      = lane_psum;
         adder_error_sum = comp_en ? lane_err : 16'd0;
      end
      if (accept)
         in_ready_c[grant_idx] = 1'b1;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_lane  = out_lane_q;

   // Single-entry result buffer, round-robin pointer and saturating compensation counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= 24'd0;
         out_lane_q  <= '0;
         rr_ptr      <= '0;
         comp_count  <= 16'd0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= adder_sum;
            out_lane_q  <= grant_idx;
            rr_ptr      <= next_ptr;
            if (comp_en && (lane_err != 16'd0) && (comp_count != 16'hFFFF))
               comp_count <= comp_count + 16'd1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule
